// File: rtl/key_toggle_bank_pkg.sv
// Shared constants and per-channel status type for the key toggle bank.
// Board defaults live here so every user picks up the same values.
package key_toggle_bank_pkg;

  localparam int unsigned KEY_DEBOUNCE_DEFAULT = 500000;
  localparam bit          KEY_ACTIVE_LOW_DE10  = 1'b1;

  // One channel's registered outputs plus the strobe about to be registered.
  typedef struct packed {
    logic pressed;
    logic pulse;
    logic pulse_next;
  } key_chan_t;

endpackage

// File: rtl/key_toggle_bank_debounce.sv
// One key channel: polarity normalise, 2-flop sync, debounce counter,
// debounced level and a one-cycle press strobe.
module key_debounce
  import key_toggle_bank_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter bit          KEY_ACTIVE_LOW  = KEY_ACTIVE_LOW_DE10
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      key_raw,
  output key_chan_t chan
);

  localparam int unsigned  CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          p;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_q, pressed_d;
  logic          pulse_q, pulse_d;

  // Sync flops reset to 0, which after normalisation is the released level.
  assign p = key_raw ^ KEY_ACTIVE_LOW;

  always_comb begin
    sync_d    = {sync_q[0], p};
    cnt_d     = cnt_q + 1'b1;
    pressed_d = pressed_q;
    if (sync_q[1] == pressed_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      pressed_d = sync_q[1];
      cnt_d     = '0;
    end
    pulse_d = pressed_d & ~pressed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      pulse_q   <= pulse_d;
    end
  end

  assign chan.pressed    = pressed_q;
  assign chan.pulse      = pulse_q;
  assign chan.pulse_next = pulse_d;

endmodule

// File: rtl/key_toggle_bank.sv
// N-channel pushbutton front end: debounced key levels, press strobes and
// a per-key toggle (mode) register with synchronous clear.
module key_toggle_bank
  import key_toggle_bank_pkg::*;
#(
  parameter int unsigned        N_KEYS          = 2,
  parameter int unsigned        DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter bit                 KEY_ACTIVE_LOW  = KEY_ACTIVE_LOW_DE10,
  parameter logic [N_KEYS-1:0]  MODE_INIT       = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic              clr,
  output logic [N_KEYS-1:0] mode,
  output logic [N_KEYS-1:0] key_pressed,
  output logic [N_KEYS-1:0] press_pulse
);

  key_chan_t [N_KEYS-1:0] chan;
  logic      [N_KEYS-1:0] press_next;
  logic      [N_KEYS-1:0] mode_q, mode_d;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_key (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_raw (key_raw[i]),
      .chan    (chan[i])
    );
    assign press_next[i]  = chan[i].pulse_next;
    assign key_pressed[i] = chan[i].pressed;
    assign press_pulse[i] = chan[i].pulse;
  end

  // Toggle lands on the same edge as the strobe; clr overrides any press.
  always_comb begin
    mode_d = mode_q ^ press_next;
    if (clr) mode_d = MODE_INIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_INIT;
    else        mode_q <= mode_d;
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_key_toggle_bank.sv
// Directed bench for key_toggle_bank with a 4-cycle debounce window.
module tb_key_toggle_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_raw;
  logic       clr;
  logic [1:0] mode, key_pressed, press_pulse;

  int checks = 0;
  int errors = 0;

  key_toggle_bank #(
    .N_KEYS          (2),
    .DEBOUNCE_CYCLES (4),
    .KEY_ACTIVE_LOW  (1'b1),
    .MODE_INIT       (2'b00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_raw     (key_raw),
    .clr         (clr),
    .mode        (mode),
    .key_pressed (key_pressed),
    .press_pulse (press_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n ticks with no strobe expected.
  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, press_pulse, 2'b00);
    end
  endtask

  // Apply a raw level, expect silence for 5 ticks, then the strobe on the 6th.
  task automatic press(input logic [1:0] raw, input logic [1:0] pulse_exp,
                       input logic [1:0] mode_exp, input string tag);
    key_raw = raw;
    quiet(5, {tag, "_pre"});
    tick();
    chk({tag, "_pulse"}, press_pulse, pulse_exp);
    chk({tag, "_mode"}, mode, mode_exp);
  endtask

  initial begin
    rst_n   = 1'b0;
    key_raw = 2'b11;
    clr     = 1'b0;
    #3;
    chk("rst_mode", mode, 2'b00);
    chk("rst_kp", key_pressed, 2'b00);
    chk("rst_pulse", press_pulse, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_mode", mode, 2'b00);

    // Clean press on key0.
    press(2'b10, 2'b01, 2'b01, "clean");
    chk("clean_kp", key_pressed, 2'b01);
    tick();
    chk("clean_pulse_gone", press_pulse, 2'b00);
    chk("clean_mode_hold", mode, 2'b01);

    // Bounce on key1 shorter than the debounce window.
    for (int i = 0; i < 20; i++) begin
      key_raw[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      chk("bounce_pulse", press_pulse, 2'b00);
    end
    key_raw[1] = 1'b1;
    quiet(10, "bounce_settle");
    chk("bounce_mode", mode, 2'b01);
    chk("bounce_kp", key_pressed, 2'b01);

    // Long hold gives no extra toggle; release, then re-press toggles back.
    quiet(50, "hold");
    chk("hold_mode", mode, 2'b01);
    key_raw = 2'b11;
    quiet(8, "release");
    chk("release_kp", key_pressed, 2'b00);
    chk("release_mode", mode, 2'b01);
    press(2'b10, 2'b01, 2'b00, "repress");
    key_raw = 2'b11;
    quiet(8, "release2");

    // Simultaneous presses.
    press(2'b00, 2'b11, 2'b11, "both");
    chk("both_kp", key_pressed, 2'b11);
    key_raw = 2'b11;
    quiet(8, "release3");
    press(2'b10, 2'b01, 2'b10, "key0_only");
    key_raw = 2'b11;
    quiet(8, "release4");

    // clr coincident with both strobes: clr wins, strobes still fire.
    key_raw = 2'b00;
    quiet(5, "clr_pre");
    clr = 1'b1;
    tick();
    chk("clr_pulse", press_pulse, 2'b11);
    chk("clr_mode", mode, 2'b00);
    clr = 1'b0;
    tick();
    chk("clr_after_pulse", press_pulse, 2'b00);
    chk("clr_after_mode", mode, 2'b00);
    key_raw = 2'b11;
    quiet(8, "release5");

    // Reset mid-debounce on key1, with key0 already accepted.
    press(2'b10, 2'b01, 2'b01, "pre_rst");
    key_raw = 2'b00;
    repeat (4) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mode", mode, 2'b00);
    chk("async_rst_kp", key_pressed, 2'b00);
    chk("async_rst_pulse", press_pulse, 2'b00);
    tick();
    tick();
    chk("in_rst_mode", mode, 2'b00);
    rst_n = 1'b1;
    press(2'b00, 2'b11, 2'b11, "post_rst");
    chk("post_rst_kp", key_pressed, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
